// File: rtl/voice_pkg.sv
// Shared types and helpers for the polyphonic voice phase/address generator.
package voice_pkg;
  localparam int PHASE_W = 32;
  localparam int ADDR_W  = 8;
  localparam int BANK_W  = 2;

  typedef enum logic [1:0] {V_IDLE, V_ACTIVE, V_RELEASE} voice_state_e;

  typedef logic [PHASE_W-1:0] phase_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [BANK_W-1:0]  bank_t;

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) n += 32'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/voice_channel.sv
// One voice: lifecycle FSM, phase accumulator, release counter and latched bank.
// VOICE_INTERP_FRAC_EN adds the sub-address phase fraction output.
module voice_channel
  import voice_pkg::*;
#(
  parameter int PHASE_WIDTH    = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int WAVE_SEL_WIDTH = 2,
  parameter int RELEASE_TICKS  = 64
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      tick_in,
  input  logic                      gate_in,
  input  logic                      admit_in,
  input  logic [PHASE_WIDTH-1:0]    inc_in,
  input  logic [WAVE_SEL_WIDTH-1:0] wave_sel_in,
  output logic                      rise_out,
  output voice_state_e              state_out,
  output logic [ADDR_WIDTH-1:0]     msb_out,
`ifdef VOICE_INTERP_FRAC_EN
  output logic [PHASE_WIDTH-ADDR_WIDTH-1:0] frac_out,
`endif
  output logic [WAVE_SEL_WIDTH-1:0] bank_out
);
  localparam int RW = (RELEASE_TICKS > 1) ? $clog2(RELEASE_TICKS) : 1;

  voice_state_e              state_q, state_d;
  logic [PHASE_WIDTH-1:0]    phase_q, phase_d, phase_nxt;
  logic [WAVE_SEL_WIDTH-1:0] bank_q, bank_d;
  logic [RW-1:0]             rel_cnt_q, rel_cnt_d;
  logic                      gate_prev_q, gate_prev_d;
  logic                      rise;

  assign rise      = gate_in & ~gate_prev_q;
  assign phase_nxt = phase_q + inc_in;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bank_d      = bank_q;
    rel_cnt_d   = rel_cnt_q;
    gate_prev_d = gate_prev_q;
    if (tick_in) begin
      gate_prev_d = gate_in;
      case (state_q)
        V_IDLE: if (rise && admit_in) begin
          state_d = V_ACTIVE;
          phase_d = '0;
          bank_d  = wave_sel_in;
        end
        V_ACTIVE: begin
          phase_d = phase_nxt;
          if (!gate_in) begin
            state_d   = V_RELEASE;
            rel_cnt_d = '0;
          end
        end
        V_RELEASE: begin
          if (rise) begin
            state_d = V_ACTIVE;
            phase_d = '0;
            bank_d  = wave_sel_in;
          end else if (rel_cnt_q == RW'(RELEASE_TICKS-1)) begin
            state_d = V_IDLE;
            phase_d = '0;
          end else begin
            phase_d   = phase_nxt;
            rel_cnt_d = rel_cnt_q + 1'b1;
          end
        end
        default: state_d = V_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= V_IDLE;
      phase_q     <= '0;
      bank_q      <= '0;
      rel_cnt_q   <= '0;
      gate_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bank_q      <= bank_d;
      rel_cnt_q   <= rel_cnt_d;
      gate_prev_q <= gate_prev_d;
    end
  end

  assign rise_out  = rise;
  assign state_out = state_q;
  assign msb_out   = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign bank_out  = bank_q;
`ifdef VOICE_INTERP_FRAC_EN
  assign frac_out  = phase_q[PHASE_WIDTH-ADDR_WIDTH-1:0];
`endif
endmodule

// File: rtl/voice_phase_addr_gen.sv
// Polyphonic wavetable address generator: per-voice channels, polyphony-cap arbiter, output registers.
// VOICE_INTERP_FRAC_EN adds frac_out (phase bits below the table address).
module voice_phase_addr_gen
  import voice_pkg::*;
#(
  parameter int NUM_VOICES     = 8,
  parameter int PHASE_WIDTH    = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int WAVE_SEL_WIDTH = 2,
  parameter int MAX_ACTIVE     = 4,
  parameter int RELEASE_TICKS  = 64
) (
  input  logic                                                  clk_in,
  input  logic                                                  rst_in,
  input  logic                                                  sample_tick_in,
  input  logic [NUM_VOICES-1:0]                                 gate_in,
  input  logic [NUM_VOICES-1:0][PHASE_WIDTH-1:0]                phase_inc_in,
  input  logic [NUM_VOICES-1:0][WAVE_SEL_WIDTH-1:0]             wave_sel_in,
  output logic [NUM_VOICES-1:0][WAVE_SEL_WIDTH+ADDR_WIDTH-1:0]  addr_out,
  output logic                                                  addr_valid_out,
  output logic [NUM_VOICES-1:0]                                 active_voices_out,
`ifdef VOICE_INTERP_FRAC_EN
  output logic [NUM_VOICES-1:0][PHASE_WIDTH-ADDR_WIDTH-1:0]     frac_out,
`endif
  output logic [$clog2(NUM_VOICES+1)-1:0]                       num_voices_out
);
  localparam int NW     = $clog2(NUM_VOICES+1);
  localparam int AW     = WAVE_SEL_WIDTH + ADDR_WIDTH;
  localparam int FW     = PHASE_WIDTH - ADDR_WIDTH;
  localparam int STAGES = 1;

  voice_state_e                           state [NUM_VOICES];
  logic [NUM_VOICES-1:0][ADDR_WIDTH-1:0]     msb;
  logic [NUM_VOICES-1:0][WAVE_SEL_WIDTH-1:0] bank;
  logic [NUM_VOICES-1:0]                     rise, admit, busy;
`ifdef VOICE_INTERP_FRAC_EN
  logic [NUM_VOICES-1:0][FW-1:0]             frac;
  logic [NUM_VOICES-1:0][FW-1:0]             frac_q, frac_d;
`endif

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    voice_channel #(
      .PHASE_WIDTH(PHASE_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
      .WAVE_SEL_WIDTH(WAVE_SEL_WIDTH), .RELEASE_TICKS(RELEASE_TICKS)
    ) u_ch (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .tick_in     (sample_tick_in),
      .gate_in     (gate_in[i]),
      .admit_in    (admit[i]),
      .inc_in      (phase_inc_in[i]),
      .wave_sel_in (wave_sel_in[i]),
      .rise_out    (rise[i]),
      .state_out   (state[i]),
      .msb_out     (msb[i]),
`ifdef VOICE_INTERP_FRAC_EN
      .frac_out    (frac[i]),
`endif
      .bank_out    (bank[i])
    );
    assign busy[i] = (state[i] != V_IDLE);
  end

  // Slots come from the pre-tick occupancy, so a voice finishing its release this tick frees nothing yet.
  always_comb begin
    int slots;
    int granted;
    admit   = '0;
    granted = 0;
    slots   = MAX_ACTIVE - int'(popcount(64'(busy)));
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!busy[i] && rise[i] && granted < slots) begin
        admit[i] = 1'b1;
        granted++;
      end
    end
  end

  logic [STAGES:0]               vld_pipe_q, vld_pipe_d;
  logic [NUM_VOICES-1:0][AW-1:0] addr_q, addr_d;
  logic [NUM_VOICES-1:0]         active_q, active_d;
  logic [NW-1:0]                 num_q, num_d;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-1:0], sample_tick_in};
    addr_d     = addr_q;
    active_d   = active_q;
    num_d      = num_q;
`ifdef VOICE_INTERP_FRAC_EN
    frac_d     = frac_q;
`endif
    if (vld_pipe_q[0]) begin
      active_d = busy;
      num_d    = NW'(popcount(64'(busy)));
      for (int i = 0; i < NUM_VOICES; i++) begin
        addr_d[i] = busy[i] ? {bank[i], msb[i]} : '0;
`ifdef VOICE_INTERP_FRAC_EN
        frac_d[i] = busy[i] ? frac[i] : '0;
`endif
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_pipe_q <= '0;
      addr_q     <= '0;
      active_q   <= '0;
      num_q      <= '0;
`ifdef VOICE_INTERP_FRAC_EN
      frac_q     <= '0;
`endif
    end else begin
      vld_pipe_q <= vld_pipe_d;
      addr_q     <= addr_d;
      active_q   <= active_d;
      num_q      <= num_d;
`ifdef VOICE_INTERP_FRAC_EN
      frac_q     <= frac_d;
`endif
    end
  end

  assign addr_out          = addr_q;
  assign addr_valid_out    = vld_pipe_q[STAGES];
  assign active_voices_out = active_q;
  assign num_voices_out    = num_q;
`ifdef VOICE_INTERP_FRAC_EN
  assign frac_out          = frac_q;
`endif
endmodule

// File: tb/tb_voice_phase_addr_gen.sv
// Directed bench for voice_phase_addr_gen: lifecycle, admission cap, release tail, bank latch, async reset.
module tb_voice_phase_addr_gen;
  localparam int NV = 8;
  localparam int PW = 32;
  localparam int AW = 8;
  localparam int WS = 2;

  logic                        clk_in, rst_in, sample_tick_in;
  logic [NV-1:0]               gate_in;
  logic [NV-1:0][PW-1:0]       phase_inc_in;
  logic [NV-1:0][WS-1:0]       wave_sel_in;
  logic [NV-1:0][WS+AW-1:0]    addr_out;
  logic                        addr_valid_out;
  logic [NV-1:0]               active_voices_out;
  logic [3:0]                  num_voices_out;
`ifdef VOICE_INTERP_FRAC_EN
  logic [NV-1:0][PW-AW-1:0]    frac_out;
`endif

  voice_phase_addr_gen dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .sample_tick_in    (sample_tick_in),
    .gate_in           (gate_in),
    .phase_inc_in      (phase_inc_in),
    .wave_sel_in       (wave_sel_in),
    .addr_out          (addr_out),
    .addr_valid_out    (addr_valid_out),
    .active_voices_out (active_voices_out),
`ifdef VOICE_INTERP_FRAC_EN
    .frac_out          (frac_out),
`endif
    .num_voices_out    (num_voices_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One isolated tick; returns on the negedge after the valid pulse is registered.
  task automatic tick();
    @(negedge clk_in); sample_tick_in = 1'b1;
    @(negedge clk_in); sample_tick_in = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    gate_in = '0; phase_inc_in = '0; wave_sel_in = '0; sample_tick_in = 1'b0;
    @(negedge clk_in); rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
  endtask

  initial begin
    rst_in = 1'b0; sample_tick_in = 1'b0;
    gate_in = '0; phase_inc_in = '0; wave_sel_in = '0;
    repeat (2) @(negedge clk_in);
    chk("rst_addr",   64'(addr_out), 64'd0);
    chk("rst_valid",  64'(addr_valid_out), 64'd0);
    chk("rst_active", 64'(active_voices_out), 64'd0);
    chk("rst_num",    64'(num_voices_out), 64'd0);
    rst_in = 1'b1;
    @(negedge clk_in);

    // basic accumulation, latency, pulse width, back-to-back ticks
    phase_inc_in[0] = 32'h0100_0000; gate_in[0] = 1'b1;
    tick();
    chk("t1_addr0",  64'(addr_out[0]), 64'h000);
    chk("t1_valid",  64'(addr_valid_out), 64'd1);
    chk("t1_num",    64'(num_voices_out), 64'd1);
    @(negedge clk_in);
    chk("t1_pulse",  64'(addr_valid_out), 64'd0);
    tick();
    chk("t1_addr1",  64'(addr_out[0]), 64'h001);
    @(negedge clk_in); sample_tick_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in); sample_tick_in = 1'b0;
    chk("t1_b2b_v0", 64'(addr_valid_out), 64'd1);
    chk("t1_b2b_a0", 64'(addr_out[0]), 64'h002);
    @(negedge clk_in);
    chk("t1_b2b_v1", 64'(addr_valid_out), 64'd1);
    chk("t1_b2b_a1", 64'(addr_out[0]), 64'h003);
    @(negedge clk_in);
    chk("t1_b2b_end", 64'(addr_valid_out), 64'd0);

    // silent wrap with inc = 2^31
    do_reset();
    phase_inc_in[1] = 32'h8000_0000; gate_in[1] = 1'b1;
    tick();
    chk("t2_start", 64'(addr_out[1]), 64'h00);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_wrap", 64'(addr_out[1]), (k % 2 == 0) ? 64'h80 : 64'h00);
    end
    chk("t2_num", 64'(num_voices_out), 64'd1);

    // polyphony cap, release tail, no late admission while gate holds
    do_reset();
    gate_in = 8'h3F;
    tick();
    chk("t3_active", 64'(active_voices_out), 64'h0F);
    chk("t3_num",    64'(num_voices_out), 64'd4);
    gate_in[0] = 1'b0;
    for (int k = 0; k < 64; k++) begin
      tick();
      chk("t3_tail", 64'(active_voices_out), 64'h0F);
    end
    tick();
    chk("t3_freed",   64'(active_voices_out), 64'h0E);
    chk("t3_num3",    64'(num_voices_out), 64'd3);
    chk("t3_addr0",   64'(addr_out[0]), 64'h0);
    gate_in[4] = 1'b0;
    tick();
    chk("t3_held",    64'(active_voices_out), 64'h0E);
    gate_in[4] = 1'b1;
    tick();
    chk("t3_rerise",  64'(active_voices_out), 64'h1E);
    chk("t3_num4",    64'(num_voices_out), 64'd4);

    // release phase advance and retrigger
    do_reset();
    phase_inc_in[2] = 32'h0100_0000; gate_in[2] = 1'b1;
    repeat (3) tick();
    chk("t4_pre",  64'(addr_out[2]), 64'h002);
    gate_in[2] = 1'b0;
    tick();
    chk("t4_rel",  64'(addr_out[2]), 64'h003);
    chk("t4_act",  64'(active_voices_out), 64'h04);
    repeat (9) tick();
    chk("t4_rel9", 64'(addr_out[2]), 64'h00C);
    gate_in[2] = 1'b1;
    tick();
    chk("t4_retrig", 64'(addr_out[2]), 64'h000);
    chk("t4_num",    64'(num_voices_out), 64'd1);
    tick();
    chk("t4_adv",    64'(addr_out[2]), 64'h001);

    // bank latched at note-on, re-latched only on retrigger
    do_reset();
    wave_sel_in[3] = 2'b11; phase_inc_in[3] = 32'h0100_0000; gate_in[3] = 1'b1;
    tick();
    chk("t5_on",   64'(addr_out[3]), 64'h300);
    wave_sel_in[3] = 2'b01;
    tick();
    chk("t5_hold", 64'(addr_out[3]), 64'h301);
    gate_in[3] = 1'b0;
    tick();
    chk("t5_rel",  64'(addr_out[3]), 64'h302);
    gate_in[3] = 1'b1;
    tick();
    chk("t5_retrig", 64'(addr_out[3]), 64'h100);

    // async reset mid-note
    do_reset();
    phase_inc_in[0] = 32'h0000_0123; phase_inc_in[1] = 32'h0100_0000;
    gate_in[1:0] = 2'b11;
    tick();
`ifdef VOICE_INTERP_FRAC_EN
    chk("t6_frac0", 64'(frac_out[0]), 64'h0);
`endif
    tick();
    chk("t6_addr1", 64'(addr_out[1]), 64'h001);
    chk("t6_num",   64'(num_voices_out), 64'd2);
`ifdef VOICE_INTERP_FRAC_EN
    chk("t6_frac",  64'(frac_out[0]), 64'h123);
`endif
    rst_in = 1'b0;
    #1;
    chk("t6_rst_addr",   64'(addr_out), 64'd0);
    chk("t6_rst_valid",  64'(addr_valid_out), 64'd0);
    chk("t6_rst_active", 64'(active_voices_out), 64'd0);
    chk("t6_rst_num",    64'(num_voices_out), 64'd0);
    @(negedge clk_in); rst_in = 1'b1;
    gate_in = '0;
    tick();
    chk("t6_after", 64'(active_voices_out), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
